// File: rtl/alu_core.sv
// alu_core: registered 16-op ALU with flags and a non-restoring division step
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] DI,
  input  logic [3:0]       INST,
  input  logic             CI,
  input  logic             FirstCyc,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] DO,
  output logic [3:0]       FLAGS
);
  logic [WIDTH-1:0] w_x, w_y, w_z, w_do;
  logic             w_cin, w_sub, w_ovf_add, w_ovf, w_carry;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] r_z, r_do;
  logic [3:0]       r_flags;
  assign w_sub = FirstCyc || (A[WIDTH-1] == B[WIDTH-1]);
  always_comb begin
    w_x   = A;
    w_y   = '0;
    w_cin = 1'b1;
    case (INST)
      4'd1: begin w_y = '1; w_cin = 1'b0; end
      4'd2: begin w_y = B; w_cin = CI; end
      4'd3: begin w_y = ~B; w_cin = ~CI; end
      4'd4, 4'd5: begin w_x = '0; w_y = ~A; end
      4'd6: begin w_x = B; w_y = w_sub ? ~A : A; w_cin = w_sub; end
      4'd7: begin w_x = '0; w_y = ~B; end
      default: ;
    endcase
  end
  assign w_sum     = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
  assign w_ovf_add = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
  always_comb begin
    w_z = w_sum[WIDTH-1:0];
    case (INST)
      4'd4:  w_z = A[WIDTH-1] ? w_sum[WIDTH-1:0] : A;
      4'd6:  w_z = {w_sum[WIDTH-2:0], DI[WIDTH-1]};
      4'd8:  w_z = A & B;
      4'd9:  w_z = A | B;
      4'd10: w_z = A ^ B;
      4'd11: w_z = ~B;
      4'd12: w_z = A;
      4'd13: w_z = ~A;
      4'd14: w_z = '0;
      4'd15: w_z = WIDTH'(1);
      default: ;
    endcase
  end
  // abs only overflows (and only uses the adder) for negative A; it never reports carry
  assign w_ovf   = INST[3] ? 1'b0 : (INST == 4'd4) ? (A[WIDTH-1] && w_ovf_add) : w_ovf_add;
  assign w_carry = !INST[3] && (INST != 4'd4) && w_sum[WIDTH];
  assign w_do    = (INST == 4'd6) ? {DI[WIDTH-2:0], w_sum[WIDTH-1] == A[WIDTH-1]} : DI;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_z     <= '0;
      r_do    <= '0;
      r_flags <= '0;
    end else begin
      r_z     <= w_z;
      r_do    <= w_do;
      r_flags <= {1'b0, w_z == '0, w_carry, w_ovf};
    end
  end
  assign Z     = r_z;
  assign DO    = r_do;
  assign FLAGS = r_flags;
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed-vector check of alu_core ops, flags and division stepping
module tb_alu_core;
  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] A, B, DI;
  logic [3:0]  INST;
  logic        CI, FirstCyc;
  logic [31:0] Z, DO;
  logic [3:0]  FLAGS;
  int          n_cmp = 0;
  int          n_bad = 0;

  alu_core #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .DI(DI), .INST(INST),
    .CI(CI), .FirstCyc(FirstCyc), .Z(Z), .DO(DO), .FLAGS(FLAGS)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic op(input logic [3:0] i, input logic [31:0] a, input logic [31:0] b,
                    input logic ci, input logic fc, input logic [31:0] di);
    INST = i; A = a; B = b; CI = ci; FirstCyc = fc; DI = di;
    @(posedge CLK);
    #1;
  endtask

  task automatic res(input string tag, input logic [31:0] z, input logic [3:0] f);
    chk({tag, ".Z"}, Z, z);
    chk({tag, ".F"}, {28'd0, FLAGS}, {28'd0, f});
  endtask

  initial begin
    RST = 1'b1;
    op(4'd2, 32'h1234, 32'h1, 1'b0, 1'b0, 32'hFFFF);
    res("reset", 32'h0, 4'h0);
    chk("reset.DO", DO, 32'h0);
    RST = 1'b0;

    op(4'd2, 32'h1, 32'h1, 1'b0, 1'b0, 32'h0);           res("add", 32'h2, 4'h0);
    op(4'd2, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0);    res("add_ovf", 32'h80000000, 4'h1);
    op(4'd2, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0);    res("add_cz", 32'h0, 4'h6);
    op(4'd2, 32'h1, 32'h1, 1'b1, 1'b0, 32'h0);           res("add_ci", 32'h3, 4'h0);
    op(4'd3, 32'h5, 32'h5, 1'b0, 1'b0, 32'h0);           res("sub", 32'h0, 4'h6);
    op(4'd3, 32'h5, 32'h3, 1'b1, 1'b0, 32'h0);           res("sub_ci", 32'h1, 4'h2);
    op(4'd0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, 32'h0);    res("inc", 32'h0, 4'h6);
    op(4'd1, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);           res("dec", 32'hFFFFFFFF, 4'h0);
    op(4'd4, 32'h80000000, 32'h0, 1'b0, 1'b0, 32'h0);    res("abs_min", 32'h80000000, 4'h1);
    op(4'd4, 32'hFFFFFFFB, 32'h0, 1'b0, 1'b0, 32'h0);    res("abs_neg", 32'h5, 4'h0);
    op(4'd4, 32'h5, 32'h0, 1'b0, 1'b0, 32'h0);           res("abs_pos", 32'h5, 4'h0);
    op(4'd5, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);           res("neg0", 32'h0, 4'h6);
    op(4'd5, 32'h80000000, 32'h0, 1'b0, 1'b0, 32'h0);    res("negmin", 32'h80000000, 4'h1);
    op(4'd7, 32'h0, 32'h3, 1'b0, 1'b0, 32'h0);           res("negb", 32'hFFFFFFFD, 4'h0);

    op(4'd8,  32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b1, 32'h12345678);
    res("and", 32'hF000F000, 4'h0);
    chk("pass.DO", DO, 32'h12345678);
    op(4'd9,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 32'h0); res("or",   32'hFFF0FFF0, 4'h0);
    op(4'd10, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 32'h0); res("xor",  32'h0FF00FF0, 4'h0);
    op(4'd11, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 32'h0); res("notb", 32'h00FF00FF, 4'h0);
    op(4'd12, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 32'h0); res("pa",   32'hF0F0F0F0, 4'h0);
    op(4'd13, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 32'h0); res("nota", 32'h0F0F0F0F, 4'h0);
    op(4'd14, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 32'h0); res("zero", 32'h0, 4'h4);
    op(4'd15, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 32'h0); res("one",  32'h1, 4'h0);

    // 7 / 2 over 32 steps: DO feeds DI, Z feeds B
    op(4'd6, 32'h2, 32'h0, 1'b0, 1'b1, 32'h7);
    res("div1", 32'hFFFFFFFC, 4'h0);
    chk("div1.DO", DO, 32'h0000000E);
    op(4'd6, 32'h2, Z, 1'b0, 1'b0, DO);
    res("div2", 32'hFFFFFFFC, 4'h0);
    chk("div2.DO", DO, 32'h0000001C);
    for (int k = 3; k <= 31; k++) op(4'd6, 32'h2, Z, 1'b0, 1'b0, DO);
    res("div31", 32'hFFFFFFFF, 4'h0);
    chk("div31.DO", DO, 32'h80000000);
    op(4'd6, 32'h2, Z, 1'b0, 1'b0, DO);
    res("div32", 32'h3, 4'h2);
    chk("div32.DO", DO, 32'h00000001);

    op(4'd6, 32'h2, 32'h0, 1'b0, 1'b1, 32'h7);
    op(4'd6, 32'h2, Z, 1'b0, 1'b0, DO);
    RST = 1'b1;
    op(4'd6, 32'h2, Z, 1'b0, 1'b0, DO);
    res("midrst", 32'h0, 4'h0);
    chk("midrst.DO", DO, 32'h0);
    RST = 1'b0;
    op(4'd15, 32'h0, 32'h0, 1'b0, 1'b0, 32'hA5A5A5A5);
    res("post", 32'h1, 4'h0);
    chk("post.DO", DO, 32'hA5A5A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_core.md
Name:
alu_core

Overview:
- 32-bit registered ALU providing 16 operations: arithmetic, logic, constants, and one non-restoring division iteration step.
- Outputs a result Z, a 4-bit flag vector, and a 32-bit division shift register (DO) that the surrounding datapath feeds back into DI on the next cycle.
- Sits in the datapath functional unit.
- All outputs are registered on CLK.

Parameters:
- WIDTH, 32, datapath width of A, B, DI, Z, DO. All values below assume 32.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous, active-high reset
- A  input  32  operand A
- B  input  32  operand B
- DI  input  32  division shift-register input (DO fed back externally)
- INST  input  4  operation select
- CI  input  1  carry/borrow in; affects INST 2 and 3 only
- FirstCyc  input  1  first division iteration; affects INST 6 only
- Z  output  32  registered result
- DO  output  32  registered division shift-register output
- FLAGS  output  4  registered flags: [0] OVF, [1] Carry, [2] Zero, [3] reserved, always 0

Behaviour:
- Inputs are sampled on the rising CLK edge; Z, DO and FLAGS update on that edge. Latency is 1 cycle, with one new operation accepted every cycle and no handshake.
- RST=1 at an edge sets Z=0, DO=0, FLAGS=0. This overrides any operation in flight, and the result of the first operation after reset is visible one edge later.
- All arithmetic is modulo 2^32.
- OVF means a two's-complement signed overflow of the computed sum.
- Carry means the raw carry-out of bit 31 of the internal adder, computed as X + Y + cin.
- Per INST:
  - 0: Z=A+1. Adder A+0+1.
  - 1: Z=A-1. Adder A+FFFFFFFF+0.
  - 2: Z=A+B+CI. Adder A+B+CI.
  - 3: Z=A-B-CI. Adder A+~B+(~CI).
  - 4: Z=|A|. If A[31]=1, Z=~A+1, otherwise Z=A. OVF=1 only for A=80000000, where Z=80000000. Carry=0.
  - 5: Z=-A. Adder 0+~A+1, so Carry=1 only when A=0 and OVF=1 only when A=80000000.
  - 6: division step, detailed below.
  - 7: Z=-B. Adder 0+~B+1; flags analogous to op 5.
  - 8: Z=A&B.
  - 9: Z=A|B.
  - 10: Z=A^B.
  - 11: Z=~B.
  - 12: Z=A.
  - 13: Z=~A.
  - 14: Z=0.
  - 15: Z=1.
- Ops 8-15: OVF=0, Carry=0.
- Zero flag = (Z==0) for every op, evaluated on the new result.
- FLAGS[3]=0 always.
- Division step (INST 6), with A = divisor and B = partial remainder:
  - R = B-A (B+~A+1) if FirstCyc=1 or A[31]==B[31]; otherwise R = B+A.
  - Z = {R[30:0], DI[31]}, i.e. shift left by 1 and bring in the next dividend bit from DI.
  - Quotient bit q = (R[31]==A[31]) ? 1 : 0.
  - DO = {DI[30:0], q}.
  - OVF and Carry come from the R adder; Zero is evaluated on Z.
- DO for ops other than 6: DO = DI (registered pass-through).
- FirstCyc and CI are ignored by the ops that do not use them.

Test Plan:
- RST=1 for one edge, then release -> Z=00000000, DO=00000000, FLAGS=0 while in reset.
- INST=2, CI=0, A=00000001, B=00000001 -> after one edge Z=00000002, FLAGS=0.
- INST=2, A=7FFFFFFF, B=00000001, CI=0 -> Z=80000000, FLAGS=1 (OVF). Then A=FFFFFFFF, B=00000001 -> Z=0, FLAGS=6 (Carry, Zero).
- INST=3, A=5, B=5, CI=0 -> Z=0, FLAGS=6. Then INST=4, A=80000000 -> Z=80000000, FLAGS=1. Then INST=5, A=0 -> Z=0, FLAGS=6.
- Logic and constant sweep, A=F0F0F0F0, B=FF00FF00 -> INST 8=F000F000, 9=FFF0FFF0, 10=0FF00FF0, 11=00FF00FF, 12=F0F0F0F0, 13=0F0F0F0F, 14=0 with FLAGS=4, 15=00000001 with FLAGS=0.
- Division, 32 cycles with DO looped to DI:
  - Setup: DI initially = 00000007 (dividend), B=0, A=00000002, INST=6, FirstCyc=1 on the first cycle only, Z fed back to B.
  - Final DO: the non-restoring quotient bits.
  - Check: first cycle gives R=FFFFFFFE, Z=FFFFFFFC, q=0, DO=0000000E.
- Mid-operation reset during the division sequence -> Z, DO, FLAGS go to 0 at the reset edge.
